tick_rate_gen: RTL and testbench

- Upstream pacing stage for the hex counter/display path.
- Produces a single-cycle `tick` that drives the counter's increment enable, at one of four selectable rates.
- Supports pause, plus single-stepping from a raw, bouncy, active-low pushbutton.
- Replaces the per-rate divider instances and the rate-select mux with one down-counter, a rate-change detector and a debounce FSM.

---
 rtl/tick_rate_gen.sv | 97 +++++++++
 tb/tb_tick_rate_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tick_rate_gen.sv
// Rate-selectable tick generator with pause and debounced single-step.
// One shared down-counter replaces per-rate dividers; step presses are debounced by a small FSM.
module tick_rate_gen #(
  parameter int unsigned      CNT_W           = 28,
  parameter longint unsigned  PERIOD_0        = 1,
  parameter longint unsigned  PERIOD_1        = 50000000,
  parameter longint unsigned  PERIOD_2        = 100000000,
  parameter longint unsigned  PERIOD_3        = 200000000,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       rate_sel,
  input  logic             run,
  input  logic             step_n,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             step_ack
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam longint unsigned PERIODS [4] = '{PERIOD_0, PERIOD_1, PERIOD_2, PERIOD_3};

  typedef enum logic {RELEASED, PRESSED} step_state_t;

  logic [CNT_W-1:0] reload_tbl [4];
  logic [1:0]       rate_q;
  logic             sync1_reg, sync2_reg;
  logic             db_level_reg;
  logic [DB_W-1:0]  db_cnt_reg;
  step_state_t      state_reg;
  logic             step_fire;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reload
      assign reload_tbl[gi] = CNT_W'(PERIODS[gi] - 64'd1);
    end
  endgenerate

  // A press is accepted the cycle after the debounced level has fallen.
  assign step_fire = (state_reg == RELEASED) && !db_level_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q       <= rate_sel;
      count        <= reload_tbl[rate_sel];
      tick         <= 1'b0;
      step_ack     <= 1'b0;
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
      state_reg    <= RELEASED;
    end else begin
      sync1_reg <= step_n;
      sync2_reg <= sync1_reg;

      if (sync2_reg != db_level_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_level_reg <= sync2_reg;
          db_cnt_reg   <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end

      case (state_reg)
        RELEASED: if (!db_level_reg) state_reg <= PRESSED;
        PRESSED:  if (db_level_reg)  state_reg <= RELEASED;
        default:  state_reg <= RELEASED;
      endcase
      step_ack <= step_fire;

      // Rate change wins over counting; a paused step may still tick that cycle.
      if (rate_sel != rate_q) begin
        rate_q <= rate_sel;
        count  <= reload_tbl[rate_sel];
        tick   <= step_fire && !run;
      end else if (run) begin
        if (count == '0) begin
          count <= reload_tbl[rate_q];
          tick  <= 1'b1;
        end else begin
          count <= count - CNT_W'(1);
          tick  <= 1'b0;
        end
      end else begin
        tick <= step_fire;
      end
    end
  end

endmodule

// File: tb/tb_tick_rate_gen.sv
// Directed bench for tick_rate_gen: periods 1,4,6,9 and a 4-cycle debounce.
module tb_tick_rate_gen;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rate_sel;
  logic             run;
  logic             step_n;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             step_ack;

  int checks = 0;
  int failures = 0;
  int cexp;

  tick_rate_gen #(
    .CNT_W(CNT_W), .PERIOD_0(1), .PERIOD_1(4), .PERIOD_2(6), .PERIOD_3(9),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .rate_sel(rate_sel), .run(run), .step_n(step_n),
    .tick(tick), .count(count), .step_ack(step_ack)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rate_sel = 2'd1; run = 1'b1; step_n = 1'b1;

    // Reset state and first free-run sequence at P=4
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("rst_tick", tick, 0);
      chk("rst_ack", step_ack, 0);
      chk("rst_count", count, 3);
    end
    reset = 1'b0;
    begin
      int seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
      for (int i = 0; i < 8; i++) begin
        edge1();
        chk("p4_count", count, seq[i]);
        chk("p4_tick", tick, (seq[i] == 3) ? 1 : 0);
        $display("p4 cycle %0d count=%0d tick=%0d", i, count, tick);
      end
    end

    // P=1: continuous tick; then switch to P=9
    rate_sel = 2'd0;
    edge1();
    chk("p1_switch_tick", tick, 0);
    chk("p1_switch_count", count, 0);
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("p1_tick", tick, 1);
      $display("p1 cycle %0d tick=%0d", i, tick);
    end
    rate_sel = 2'd3;
    edge1();
    chk("p9_switch_tick", tick, 0);
    chk("p9_switch_count", count, 8);
    for (int i = 1; i <= 9; i++) begin
      edge1();
      chk("p9_tick", tick, (i == 9) ? 1 : 0);
      chk("p9_count", count, (i == 9) ? 8 : 8 - i);
      $display("p9 cycle %0d count=%0d tick=%0d", i, count, tick);
    end

    // Pause at count=3 with P=6, then resume
    rate_sel = 2'd2;
    edge1();
    chk("p6_switch_count", count, 5);
    edge1();
    chk("p6_count4", count, 4);
    edge1();
    chk("p6_count3", count, 3);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("pause_count", count, 3);
      chk("pause_tick", tick, 0);
    end
    $display("pause held count=%0d", count);
    run = 1'b1;
    begin
      int seq [4] = '{2, 1, 0, 5};
      for (int i = 0; i < 4; i++) begin
        edge1();
        chk("resume_count", count, seq[i]);
        chk("resume_tick", tick, (i == 3) ? 1 : 0);
        $display("resume cycle %0d count=%0d tick=%0d", i, count, tick);
      end
    end

    // Paused step: held 30 cycles, one pulse at cycle 7, release silent
    run = 1'b0; step_n = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      edge1();
      chk("step_tick", tick, (k == 7) ? 1 : 0);
      chk("step_ack", step_ack, (k == 7) ? 1 : 0);
      chk("step_count", count, 5);
    end
    $display("step held done");
    step_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      edge1();
      chk("release_tick", tick, 0);
      chk("release_ack", step_ack, 0);
    end

    // Bouncy press: 0,0,1 then stable 0; step at cycle 10
    for (int k = 1; k <= 25; k++) begin
      step_n = (k == 3) ? 1'b1 : 1'b0;
      edge1();
      chk("bounce_tick", tick, (k == 10) ? 1 : 0);
      chk("bounce_ack", step_ack, (k == 10) ? 1 : 0);
    end
    $display("bounce done");
    step_n = 1'b1;
    for (int k = 0; k < 15; k++) edge1();

    // Reset during debounce with button held through it
    step_n = 1'b0;
    for (int k = 0; k < 3; k++) edge1();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_ack", step_ack, 0);
      chk("mid_rst_count", count, 5);
    end
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      edge1();
      chk("post_rst_tick", tick, (k == 7) ? 1 : 0);
      chk("post_rst_ack", step_ack, (k == 7) ? 1 : 0);
    end
    $display("reset during debounce done");
    step_n = 1'b1;
    for (int k = 0; k < 15; k++) edge1();

    // Step while running at P=4: ack only, periodic ticks undisturbed
    rate_sel = 2'd1; run = 1'b1;
    edge1();
    chk("run_step_switch_count", count, 3);
    chk("run_step_switch_tick", tick, 0);
    cexp = 3;
    step_n = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      edge1();
      chk("run_step_tick", tick, (cexp == 0) ? 1 : 0);
      cexp = (cexp == 0) ? 3 : cexp - 1;
      chk("run_step_count", count, cexp);
      chk("run_step_ack", step_ack, (k == 7) ? 1 : 0);
    end
    $display("run step done");
    step_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
